addsub_seq: RTL and testbench

Multi-cycle, parametrised adder/subtractor for the EXU ALU path. It processes the operands one CHUNK-bit slice per cycle, so WIDTH can grow without a long ripple-carry chain in one cycle. It adds a subtract mode, a RV64 word mode (the *W instructions) and valid/ready handshakes on both the input and output sides. It replaces the single-cycle combinational adder wherever a slower, registered add/sub is acceptable.

---
 rtl/addsub_seq.sv | 163 ++++++++++++++++
 tb/tb_addsub_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
//==============================================================================
// Module   : addsub_seq
// Purpose  : Multi-cycle add/subtract, one CHUNK-bit slice per cycle, with
//            RV64 word mode and valid/ready handshakes on both sides.
//            Optional signed-overflow output: define YSYX_2022040010_ADD_OVF_EN.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module addsub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             sub,
    input  logic             alu_32,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c
`ifdef YSYX_2022040010_ADD_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int c_N_FULL = WIDTH / CHUNK;
    localparam int c_N_HALF = c_N_FULL / 2;
    localparam int c_HALF   = WIDTH / 2;
    localparam int c_IDXW   = (c_N_FULL > 1) ? $clog2(c_N_FULL) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_FULL = c_IDXW'(c_N_FULL - 1);
    localparam logic [c_IDXW-1:0] c_LAST_HALF = c_IDXW'(c_N_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_s;
    logic                r_carry;
    logic                r_mode;
    logic [c_IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]    r_out_s;
    logic                r_out_c;

    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK:0]      w_sum;
    logic                w_last;
    logic [WIDTH-1:0]    w_s_next;
    logic [WIDTH-1:0]    w_result;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- slice adder
    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_carry);
    assign w_last    = (r_idx == (r_mode ? c_LAST_HALF : c_LAST_FULL));

    always_comb begin
        w_s_next = r_s;
        w_s_next[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Word mode result is the low half sign-extended; upper bits of r_s are don't-care.
    assign w_result = r_mode ? {{c_HALF{w_s_next[c_HALF-1]}}, w_s_next[c_HALF-1:0]}
                             : w_s_next;

`ifdef YSYX_2022040010_ADD_OVF_EN
    logic [CHUNK-1:0] w_low;
    logic             w_cin_msb;
    logic             r_out_ovf;

    // Carry into the top bit of the current slice, i.e. into the active MSB on the last slice.
    assign w_low     = {1'b0, w_a_chunk[CHUNK-2:0]} + {1'b0, w_b_chunk[CHUNK-2:0]}
                     + CHUNK'(r_carry);
    assign w_cin_msb = w_low[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_out_ovf <= w_cin_msb ^ w_sum[CHUNK];
        end
    end

    assign out_ovf = r_out_ovf;
`endif

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
            r_idx   <= '0;
            r_out_s <= '0;
            r_out_c <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= sub ? ~in_b : in_b;
                        r_carry <= in_c ^ sub;
                        r_mode  <= alu_32;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_s     <= w_s_next;
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + c_IDXW'(1);
                    if (w_last) begin
                        r_out_s <= w_result;
                        r_out_c <= w_sum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign out_s     = r_out_s;
    assign out_c     = r_out_c;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq.sv
//==============================================================================
// Module   : tb_addsub_seq
// Purpose  : Scoreboard bench for addsub_seq with directed vectors.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_addsub_seq;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_c = 1'b0;
    logic             sub = 1'b0;
    logic             alu_32 = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
`ifdef YSYX_2022040010_ADD_OVF_EN
    logic             out_ovf;
`endif

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_c     (in_c),
        .sub      (sub),
        .alu_32   (alu_32),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_c    (out_c)
`ifdef YSYX_2022040010_ADD_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_acc = -1;
    int   last_n   = 0;
    bit   spacing_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on handshake.
    logic prev_v = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (q.size() == 0) chk("unexpected_out_valid", 64'(1), 64'(0));
                else chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_s", out_s, e.s);
                chk("out_c", 64'(out_c), 64'(e.c));
`ifdef YSYX_2022040010_ADD_OVF_EN
                chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
`endif
            end
            prev_v = out_valid;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic s, input logic w, input logic [63:0] es,
                        input logic ec, input logic eo, input bit hold);
        exp_t x;
        int   t;
        in_a = a; in_b = b; in_c = c; sub = s; alu_32 = w; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        x.s = es; x.c = ec; x.ovf = eo; x.acc = cyc; x.lat = w ? 2 : 4;
        q.push_back(x);
        if (spacing_on && last_acc >= 0) chk("accept_spacing", 64'(cyc - last_acc), 64'(last_n + 2));
        last_acc = cyc;
        last_n   = x.lat;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || !in_ready) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int vcnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_s", out_s, 64'(0));
        chk("rst_out_c", 64'(out_c), 64'(0));
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Directed single operations
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        send(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0001, 1'b0, 1'b0, 1'b1,
             64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0);
        send(64'h5, 64'h7, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send(64'h7, 64'h5, 1'b1, 1'b1, 1'b0, 64'h1, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure: result held, new requests ignored
        out_ready = 1'b0;
        send(64'h1234, 64'h1, 1'b1, 1'b0, 1'b0, 64'h1236, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            in_a = 64'(i) * 64'h1111;
            in_b = 64'h99;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_s", out_s, 64'h1236);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after_hs", 64'(in_ready), 64'(1));
        chk("bp_out_valid_after_hs", 64'(out_valid), 64'(0));

        // Reset in the middle of RUN
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_c = 1'b0; sub = 1'b0; alu_32 = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_s", out_s, 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_after", 64'(in_ready), 64'(1));
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
        end
        chk("midrst_no_output", 64'(vcnt), 64'(0));
        send(64'h10, 64'h20, 1'b0, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back with continuous in_valid and out_ready
        spacing_on = 1'b1;
        last_acc   = -1;
        send(64'h0000_0001_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0,
             64'h0000_0001_0001_0000, 1'b0, 1'b0, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b0,
             64'h0, 1'b1, 1'b0, 1'b1);
        send(64'hAAAA_AAAA_0000_0005, 64'h5555_5555_0000_0003, 1'b0, 1'b1, 1'b1,
             64'h2, 1'b1, 1'b0, 1'b1);
        send(64'h3, 64'h5, 1'b0, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        send(64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 1'b0, 1'b0, 1'b1,
             64'h0, 1'b1, 1'b1, 1'b1);
        send(64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
